// File: rtl/imem_boot_fetch_ctrl.sv
// Instruction-memory port owner: boot loader packs bytes into words and writes them; fetch stage drives PC reads into IF/ID.
// Latency: a word is written one cycle after its 4th byte; fetch is 1 cycle from PC to IF/ID.
// Backpressure: ld_ready only in LOAD (deasserted during WRITE); stall freezes PC and IF/ID; branch flushes IF/ID.
module imem_boot_fetch_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              load_start,
    input  logic [6:0]        ld_words,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              load_done,
    output logic              busy,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_valid
);

    localparam int WIDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_FETCH = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [WIDX_W-1:0]   widx;
    logic [WIDX_W-1:0]   last_idx;
    logic [WIDX_W-1:0]   last_idx_in;
    logic [1:0]          bcnt;
    logic [DATA_W-1:0]   word;
    logic                wr_last;
    logic                start_ok;

    assign wr_last  = (widx == last_idx);
    // load_start is only honoured when no load is already in progress
    assign start_ok = load_start && ((state == S_HALT) || (state == S_FETCH));

    // Word count of 0 or beyond the memory depth means "fill the whole memory"
    always_comb begin
        if ((ld_words == 7'd0) || (int'(ld_words) > DEPTH_WORDS)) begin
            last_idx_in = WIDX_W'(DEPTH_WORDS - 1);
        end else begin
            last_idx_in = WIDX_W'(ld_words - 7'd1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HALT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory-port / handshake outputs
    always_comb begin
        state_nxt  = state;
        ld_ready   = 1'b0;
        busy       = 1'b0;
        load_done  = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        case (state)
            S_HALT: begin
                if (load_start) begin
                    state_nxt = S_LOAD;
                end else if (run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                busy     = 1'b1;
                if (ld_valid && (bcnt == 2'd3)) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                imem_we    = 1'b1;
                imem_addr  = ADDR_W'({widx, 2'b00});
                imem_wdata = word;
                if (wr_last) begin
                    load_done = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_LOAD;
                end
            end
            S_FETCH: begin
                imem_addr = pc;
                if (load_start) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_HALT;
        endcase
    end

    // Loader datapath: word index, byte lane counter and word assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx     <= '0;
            last_idx <= '0;
            bcnt     <= 2'd0;
            word     <= '0;
        end else begin
            if (start_ok) begin
                widx     <= '0;
                bcnt     <= 2'd0;
                last_idx <= last_idx_in;
            end
            if ((state == S_LOAD) && ld_valid) begin
                word[{bcnt, 3'b000} +: 8] <= ld_byte;
                bcnt                      <= bcnt + 2'd1;
            end
            if ((state == S_WRITE) && !wr_last) begin
                widx <= widx + WIDX_W'(1);
            end
        end
    end

    // Fetch datapath: PC and IF/ID register; branch beats stall, load_start beats both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            if_pc    <= '0;
            if_instr <= '0;
            if_valid <= 1'b0;
        end else begin
            case (state)
                S_HALT: begin
                    if_valid <= 1'b0;
                    if (!load_start && run) begin
                        pc <= '0;
                    end
                end
                S_WRITE: begin
                    if_valid <= 1'b0;
                    if (wr_last) begin
                        pc <= '0;
                    end
                end
                S_FETCH: begin
                    if (load_start) begin
                        if_valid <= 1'b0;
                    end else if (branch_taken) begin
                        pc       <= {branch_target[ADDR_W-1:2], 2'b00};
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + ADDR_W'(4);
                    end
                end
                default: begin
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_fetch_ctrl.sv
// Bench for imem_boot_fetch_ctrl: behavioural memory, write scoreboard, directed fetch checks.
// Latency: checks sample 1 time unit after the rising edge; writes are scored on the falling edge.
// Backpressure: loader bytes are held until ld_ready, including across WRITE cycles.
module tb_imem_boot_fetch_ctrl;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        load_start;
    logic [6:0]  ld_words;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        load_done;
    logic        busy;
    logic [7:0]  imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic [31:0] ld_data [64];
    wr_t         exp_wq  [$];
    wr_t         mon_e;

    int vectors     = 0;
    int miscompares = 0;

    imem_boot_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .load_start    (load_start),
        .ld_words      (ld_words),
        .ld_valid      (ld_valid),
        .ld_byte       (ld_byte),
        .ld_ready      (ld_ready),
        .load_done     (load_done),
        .busy          (busy),
        .imem_addr     (imem_addr),
        .imem_we       (imem_we),
        .imem_wdata    (imem_wdata),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_valid      (if_valid)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, synchronous write
    assign imem_rdata = mem[imem_addr[7:2]];
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr[7:2]] <= imem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write scoreboard: every memory write must match the next expected one
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_wq.size() == 0) begin
                chk("wr_unexpected", 32'(imem_we), 32'd0);
            end else begin
                mon_e = exp_wq.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(mon_e.a));
                chk("wr_data", imem_wdata, mon_e.d);
            end
        end
    end

    task automatic do_load(input logic [6:0] nfield, input int nwords, input bit poke);
        wr_t e;
        load_start = 1'b1;
        ld_words   = nfield;
        tick();
        load_start = 1'b0;
        ld_words   = 7'd1;
        chk("load_busy", 32'(busy), 32'd1);
        for (int w = 0; w < nwords; w++) begin
            e.a = 8'(w * 4);
            e.d = ld_data[w];
            exp_wq.push_back(e);
            ref_mem[w] = ld_data[w];
            for (int b = 0; b < 4; b++) begin
                int n;
                n        = 0;
                ld_byte  = ld_data[w][8*b +: 8];
                ld_valid = 1'b1;
                while (!ld_ready && n < 8) begin
                    tick();
                    n++;
                end
                if (!ld_ready) begin
                    chk("ld_ready_timeout", 32'(ld_ready), 32'd1);
                    ld_valid = 1'b0;
                    return;
                end
                if (poke && w == 0 && b == 1) begin
                    load_start = 1'b1;
                    ld_words   = 7'd1;
                end
                tick();
                load_start = 1'b0;
            end
            chk("wr_ld_ready", 32'(ld_ready), 32'd0);
            chk("wr_we", 32'(imem_we), 32'd1);
            chk("load_done", 32'(load_done), 32'(w == nwords - 1));
            if (w < nwords - 1) begin
                ld_byte  = ld_data[w+1][7:0];
                ld_valid = 1'b1;
            end else begin
                ld_valid = 1'b0;
            end
            tick();
        end
        chk("wq_drained", 32'(exp_wq.size()), 32'd0);
        chk("post_if_valid", 32'(if_valid), 32'd0);
        chk("post_pc", 32'(imem_addr), 32'd0);
        chk("post_done_low", 32'(load_done), 32'd0);
    endtask

    task automatic chk_if(input string tag, input logic [7:0] pc, input logic [31:0] instr);
        chk({tag, "_pc"}, 32'(if_pc), 32'(pc));
        chk({tag, "_instr"}, if_instr, instr);
        chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; load_start = 1'b0; ld_words = 7'd0;
        ld_valid = 1'b0; ld_byte = 8'd0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 8'd0;

        // T1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            run           = 1'($urandom);
            load_start    = 1'($urandom);
            ld_words      = 7'($urandom);
            ld_valid      = 1'($urandom);
            ld_byte       = 8'($urandom);
            stall         = 1'($urandom);
            branch_taken  = 1'($urandom);
            branch_target = 8'($urandom);
            #7;
            chk("rst_ctl", {28'd0, ld_ready, load_done, busy, imem_we}, 32'd0);
            chk("rst_addr", 32'(imem_addr), 32'd0);
            chk("rst_wdata", imem_wdata, 32'd0);
            chk("rst_if_pc", 32'(if_pc), 32'd0);
            chk("rst_if_instr", if_instr, 32'd0);
            chk("rst_if_valid", 32'(if_valid), 32'd0);
        end
        run = 1'b0; load_start = 1'b0; ld_words = 7'd0; ld_valid = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 8'd0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_ready", 32'(ld_ready), 32'd0);
        chk("halt_addr", 32'(imem_addr), 32'd0);
        chk("halt_if_valid", 32'(if_valid), 32'd0);

        // T2: two-word load, then fetch begins at PC 0
        ld_data[0] = 32'h1234_5678;
        ld_data[1] = 32'hDEAD_BEEF;
        do_load(7'd2, 2, 1'b0);
        tick();
        chk_if("t2_f0", 8'h00, 32'h1234_5678);
        tick();
        chk_if("t2_f1", 8'h04, 32'hDEAD_BEEF);

        // T6: full-depth loads (count 0, count >64), load_start poked mid-load
        for (int i = 0; i < 64; i++) ld_data[i] = $urandom;
        do_load(7'd0, 64, 1'b1);
        for (int i = 0; i < 64; i++) ld_data[i] = $urandom;
        do_load(7'd100, 64, 1'b0);
        tick();
        tick();
        chk_if("t6_f1", 8'h04, ref_mem[1]);

        // Reset mid-fetch clears IF/ID
        rst_n = 1'b0;
        #1;
        chk("rstf_if_valid", 32'(if_valid), 32'd0);
        chk("rstf_if_pc", 32'(if_pc), 32'd0);
        chk("rstf_if_instr", if_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // T3: run from HALT, sequential fetch
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("t3_first_valid", 32'(if_valid), 32'd0);
        chk("t3_addr0", 32'(imem_addr), 32'd0);
        tick();
        chk_if("t3_f0", 8'h00, ref_mem[0]);
        tick();
        chk_if("t3_f1", 8'h04, ref_mem[1]);
        tick();
        chk_if("t3_f2", 8'h08, ref_mem[2]);

        // T4: stall freezes IF/ID; branch overrides stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_if("t4_stall", 8'h08, ref_mem[2]);
            chk("t4_stall_addr", 32'(imem_addr), 32'h0C);
        end
        branch_taken  = 1'b1;
        branch_target = 8'h23;
        tick();
        branch_taken = 1'b0;
        chk("t4_flush_valid", 32'(if_valid), 32'd0);
        chk("t4_redirect_pc", 32'(imem_addr), 32'h20);
        stall = 1'b0;
        tick();
        chk_if("t4_target", 8'h20, ref_mem[8]);

        // T5: PC wrap
        branch_taken  = 1'b1;
        branch_target = 8'hFF;
        tick();
        branch_taken = 1'b0;
        chk("t5_flush_valid", 32'(if_valid), 32'd0);
        chk("t5_redirect_pc", 32'(imem_addr), 32'hFC);
        tick();
        chk_if("t5_fc", 8'hFC, ref_mem[63]);
        tick();
        chk_if("t5_wrap", 8'h00, ref_mem[0]);

        // T6: reset after two bytes of a load -> HALT, no write, memory kept
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        load_start = 1'b1;
        ld_words   = 7'd4;
        tick();
        load_start = 1'b0;
        ld_valid   = 1'b1;
        ld_byte    = 8'h11;
        tick();
        ld_byte = 8'h22;
        tick();
        ld_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstl_busy", 32'(busy), 32'd0);
        chk("rstl_ready", 32'(ld_ready), 32'd0);
        chk("rstl_we", 32'(imem_we), 32'd0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstl_halt_we", 32'(imem_we), 32'd0);
            chk("rstl_halt_busy", 32'(busy), 32'd0);
        end
        chk("rstl_wq_empty", 32'(exp_wq.size()), 32'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk_if("rstl_mem_kept", 8'h00, ref_mem[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
